// File: rtl/tdp_ram_port_arbiter.sv
// tdp_ram_port_arbiter
// Shares one port of a byte-write true-dual-port RAM between an instruction-fetch
// requester (read-only) and a data-memory requester (read / byte-write). The two
// requesters are arbitrated round-robin. At most one access is outstanding at a time.
//
// state      | meaning
// -----------+------------------------------------------------------------
// pend_q     | a response is outstanding and is being presented to owner_q
// owner_q    | requester that owns the outstanding response (REQ_IF/REQ_DM)
// pend_wr_q  | the outstanding access was a write (response data forced to 0)
// last_q     | last granted requester; the other one wins a tie

module tdp_ram_port_arbiter #(
    parameter int NumCol    = 4,
    parameter int ColWidth  = 8,
    parameter int AddrWidth = 10,
    parameter int XLen      = 32,
    localparam int DataWidth = NumCol * ColWidth
) (
    input  logic                 clk_i,
    input  logic                 rst_i,

    input  logic                 if_req_valid_i,
    output logic                 if_req_ready_o,
    input  logic [XLen-1:0]      if_req_addr_i,
    output logic                 if_rsp_valid_o,
    input  logic                 if_rsp_ready_i,
    output logic [DataWidth-1:0] if_rsp_rdata_o,

    input  logic                 dm_req_valid_i,
    output logic                 dm_req_ready_o,
    input  logic [XLen-1:0]      dm_req_addr_i,
    input  logic [NumCol-1:0]    dm_req_we_i,
    input  logic [DataWidth-1:0] dm_req_wdata_i,
    output logic                 dm_rsp_valid_o,
    input  logic                 dm_rsp_ready_i,
    output logic [DataWidth-1:0] dm_rsp_rdata_o,

    output logic                 ram_ena_o,
    output logic [NumCol-1:0]    ram_we_o,
    output logic [AddrWidth-1:0] ram_addr_o,
    output logic [DataWidth-1:0] ram_din_o,
    input  logic [DataWidth-1:0] ram_dout_i
);

    localparam int OffW = $clog2(NumCol);

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_DM = 1'b1
    } req_e;

    logic pend_q, pend_d;
    req_e owner_q, owner_d;
    logic pend_wr_q, pend_wr_d;
    req_e last_q, last_d;

    logic [AddrWidth-1:0] if_word;
    logic [AddrWidth-1:0] dm_word;
    logic                 owner_rsp_ready;
    logic                 can_issue;
    logic                 grant_if;
    logic                 grant_dm;
    logic [DataWidth-1:0] rsp_rdata;

    // Byte offset and bits above the RAM depth play no part in addressing.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_req_addr_i[XLen-1:OffW+AddrWidth], if_req_addr_i[OffW-1:0],
                                dm_req_addr_i[XLen-1:OffW+AddrWidth], dm_req_addr_i[OffW-1:0]};

    assign if_word = if_req_addr_i[OffW+AddrWidth-1:OffW];
    assign dm_word = dm_req_addr_i[OffW+AddrWidth-1:OffW];

    // State register; reset leaves IF as the winner of the first tie.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend_q    <= 1'b0;
            owner_q   <= REQ_IF;
            pend_wr_q <= 1'b0;
            last_q    <= REQ_DM;
        end else begin
            pend_q    <= pend_d;
            owner_q   <= owner_d;
            pend_wr_q <= pend_wr_d;
            last_q    <= last_d;
        end
    end

    // Grant decision, RAM port drive, response routing and next-state.
    // Reset gates the grant so every output is 0 while rst_i is high.
    always_comb begin
        pend_d     = pend_q;
        owner_d    = owner_q;
        pend_wr_d  = pend_wr_q;
        last_d     = last_q;

        owner_rsp_ready = (owner_q == REQ_DM) ? dm_rsp_ready_i : if_rsp_ready_i;
        can_issue       = !rst_i && (!pend_q || owner_rsp_ready);

        grant_if = can_issue && if_req_valid_i && (!dm_req_valid_i || (last_q == REQ_DM));
        grant_dm = can_issue && dm_req_valid_i && (!if_req_valid_i || (last_q == REQ_IF));

        if_req_ready_o = grant_if;
        dm_req_ready_o = grant_dm;

        ram_ena_o  = grant_if || grant_dm;
        ram_we_o   = '0;
        ram_addr_o = '0;
        ram_din_o  = '0;
        if (grant_dm) begin
            ram_we_o   = dm_req_we_i;
            ram_addr_o = dm_word;
            ram_din_o  = dm_req_wdata_i;
        end else if (grant_if) begin
            ram_addr_o = if_word;
            ram_din_o  = dm_req_wdata_i;
        end

        // The RAM holds doutX while idle, so a stalled response stays stable.
        rsp_rdata = pend_wr_q ? '0 : ram_dout_i;

        if_rsp_valid_o = pend_q && (owner_q == REQ_IF);
        dm_rsp_valid_o = pend_q && (owner_q == REQ_DM);
        if_rsp_rdata_o = if_rsp_valid_o ? rsp_rdata : '0;
        dm_rsp_rdata_o = dm_rsp_valid_o ? rsp_rdata : '0;

        if (grant_if || grant_dm) begin
            pend_d    = 1'b1;
            owner_d   = grant_dm ? REQ_DM : REQ_IF;
            pend_wr_d = |ram_we_o;
            last_d    = grant_dm ? REQ_DM : REQ_IF;
        end else if (pend_q && owner_rsp_ready) begin
            pend_d = 1'b0;
        end
    end

endmodule

// File: tb/tb_tdp_ram_port_arbiter.sv
// Directed bench for tdp_ram_port_arbiter with a behavioural byte-write RAM port.
// Word i of the RAM starts out as 0xA500_0000 | i.

module tb_tdp_ram_port_arbiter;

    localparam int NumCol    = 4;
    localparam int ColWidth  = 8;
    localparam int AddrWidth = 10;
    localparam int XLen      = 32;
    localparam int DataWidth = NumCol * ColWidth;

    logic                 clk_i = 1'b0;
    logic                 rst_i;
    logic                 if_req_valid_i;
    logic                 if_req_ready_o;
    logic [XLen-1:0]      if_req_addr_i;
    logic                 if_rsp_valid_o;
    logic                 if_rsp_ready_i;
    logic [DataWidth-1:0] if_rsp_rdata_o;
    logic                 dm_req_valid_i;
    logic                 dm_req_ready_o;
    logic [XLen-1:0]      dm_req_addr_i;
    logic [NumCol-1:0]    dm_req_we_i;
    logic [DataWidth-1:0] dm_req_wdata_i;
    logic                 dm_rsp_valid_o;
    logic                 dm_rsp_ready_i;
    logic [DataWidth-1:0] dm_rsp_rdata_o;
    logic                 ram_ena_o;
    logic [NumCol-1:0]    ram_we_o;
    logic [AddrWidth-1:0] ram_addr_o;
    logic [DataWidth-1:0] ram_din_o;
    logic [DataWidth-1:0] ram_dout_i;

    int checks   = 0;
    int failures = 0;

    logic [DataWidth-1:0] mem [2**AddrWidth];

    tdp_ram_port_arbiter #(
        .NumCol   (NumCol),
        .ColWidth (ColWidth),
        .AddrWidth(AddrWidth),
        .XLen     (XLen)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .if_req_valid_i (if_req_valid_i),
        .if_req_ready_o (if_req_ready_o),
        .if_req_addr_i  (if_req_addr_i),
        .if_rsp_valid_o (if_rsp_valid_o),
        .if_rsp_ready_i (if_rsp_ready_i),
        .if_rsp_rdata_o (if_rsp_rdata_o),
        .dm_req_valid_i (dm_req_valid_i),
        .dm_req_ready_o (dm_req_ready_o),
        .dm_req_addr_i  (dm_req_addr_i),
        .dm_req_we_i    (dm_req_we_i),
        .dm_req_wdata_i (dm_req_wdata_i),
        .dm_rsp_valid_o (dm_rsp_valid_o),
        .dm_rsp_ready_i (dm_rsp_ready_i),
        .dm_rsp_rdata_o (dm_rsp_rdata_o),
        .ram_ena_o      (ram_ena_o),
        .ram_we_o       (ram_we_o),
        .ram_addr_o     (ram_addr_o),
        .ram_din_o      (ram_din_o),
        .ram_dout_i     (ram_dout_i)
    );

    always #5 clk_i = ~clk_i;

    // Registered-output RAM port: reads update dout, writes and idle cycles hold it.
    always @(posedge clk_i) begin
        if (ram_ena_o) begin
            if (ram_we_o == '0) begin
                ram_dout_i <= mem[ram_addr_o];
            end else begin
                for (int b = 0; b < NumCol; b++) begin
                    if (ram_we_o[b]) mem[ram_addr_o][b*ColWidth +: ColWidth] <= ram_din_o[b*ColWidth +: ColWidth];
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic mid();
        @(negedge clk_i);
    endtask

    initial begin
        for (int i = 0; i < 2**AddrWidth; i++) mem[i] = 32'hA500_0000 | i;
        ram_dout_i     = '0;
        rst_i          = 1'b1;
        if_req_valid_i = 1'b1;
        if_req_addr_i  = 32'h0000_0004;
        if_rsp_ready_i = 1'b1;
        dm_req_valid_i = 1'b1;
        dm_req_addr_i  = 32'h0000_0008;
        dm_req_we_i    = 4'b0000;
        dm_req_wdata_i = '0;
        dm_rsp_ready_i = 1'b1;

        // Reset: requests present but nothing is granted or driven
        tick(); mid();
        check("rst_ram_ena", ram_ena_o, 0);
        check("rst_if_ready", if_req_ready_o, 0);
        check("rst_dm_ready", dm_req_ready_o, 0);
        check("rst_ram_addr", ram_addr_o, 0);
        check("rst_if_rsp_valid", if_rsp_valid_o, 0);

        // Test 1: IF reads 0x004 alone
        tick();
        rst_i = 1'b0;
        dm_req_valid_i = 1'b0;
        mid();
        check("t1_if_ready", if_req_ready_o, 1);
        check("t1_ram_ena", ram_ena_o, 1);
        check("t1_ram_addr", ram_addr_o, 1);
        check("t1_ram_we", ram_we_o, 0);
        tick();
        if_req_valid_i = 1'b0;
        mid();
        check("t1_if_rsp_valid", if_rsp_valid_o, 1);
        check("t1_if_rsp_rdata", if_rsp_rdata_o, 32'hA500_0001);
        check("t1_dm_rsp_valid", dm_rsp_valid_o, 0);

        // Test 2: DM write then read of word 2
        tick();
        dm_req_valid_i = 1'b1;
        dm_req_addr_i  = 32'h0000_0008;
        dm_req_we_i    = 4'b0011;
        dm_req_wdata_i = 32'hAABB_CCDD;
        mid();
        check("t2_dm_ready", dm_req_ready_o, 1);
        check("t2_ram_we", ram_we_o, 4'b0011);
        check("t2_ram_addr", ram_addr_o, 2);
        check("t2_ram_din", ram_din_o, 32'hAABB_CCDD);
        check("t2_if_rsp_valid_idle", if_rsp_valid_o, 0);
        tick();
        dm_req_we_i = 4'b0000;
        mid();
        check("t2_wr_ack_valid", dm_rsp_valid_o, 1);
        check("t2_wr_ack_rdata", dm_rsp_rdata_o, 0);
        check("t2_rd_ready", dm_req_ready_o, 1);
        check("t2_rd_ram_we", ram_we_o, 0);
        tick();
        dm_req_valid_i = 1'b0;
        mid();
        check("t2_rd_valid", dm_rsp_valid_o, 1);
        check("t2_rd_rdata", dm_rsp_rdata_o, 32'hA500_CCDD);

        // Test 3: both valid back to back, round-robin IF,DM,IF,DM
        tick();
        if_req_valid_i = 1'b1;
        if_req_addr_i  = 32'h0000_0010;
        dm_req_valid_i = 1'b1;
        dm_req_addr_i  = 32'h0000_0014;
        mid();
        check("t3_g0_if_ready", if_req_ready_o, 1);
        check("t3_g0_dm_ready", dm_req_ready_o, 0);
        check("t3_g0_addr", ram_addr_o, 4);
        tick(); mid();
        check("t3_g1_if_ready", if_req_ready_o, 0);
        check("t3_g1_dm_ready", dm_req_ready_o, 1);
        check("t3_g1_addr", ram_addr_o, 5);
        check("t3_g1_if_rsp_valid", if_rsp_valid_o, 1);
        check("t3_g1_if_rsp_rdata", if_rsp_rdata_o, 32'hA500_0004);
        check("t3_g1_dm_rsp_valid", dm_rsp_valid_o, 0);
        check("t3_g1_dm_rsp_rdata", dm_rsp_rdata_o, 0);
        tick(); mid();
        check("t3_g2_if_ready", if_req_ready_o, 1);
        check("t3_g2_dm_ready", dm_req_ready_o, 0);
        check("t3_g2_dm_rsp_valid", dm_rsp_valid_o, 1);
        check("t3_g2_dm_rsp_rdata", dm_rsp_rdata_o, 32'hA500_0005);
        check("t3_g2_if_rsp_valid", if_rsp_valid_o, 0);
        tick(); mid();
        check("t3_g3_dm_ready", dm_req_ready_o, 1);
        check("t3_g3_if_ready", if_req_ready_o, 0);
        check("t3_g3_if_rsp_rdata", if_rsp_rdata_o, 32'hA500_0004);
        tick();
        if_req_valid_i = 1'b0;
        dm_req_valid_i = 1'b0;
        mid();
        check("t3_last_dm_rsp_valid", dm_rsp_valid_o, 1);
        check("t3_last_dm_rsp_rdata", dm_rsp_rdata_o, 32'hA500_0005);
        check("t3_last_ram_ena", ram_ena_o, 0);

        // Test 4: IF response stalls DM for 3 cycles
        tick();
        if_req_valid_i = 1'b1;
        if_req_addr_i  = 32'h0000_000C;
        if_rsp_ready_i = 1'b0;
        mid();
        check("t4_if_ready", if_req_ready_o, 1);
        tick();
        if_req_valid_i = 1'b0;
        dm_req_valid_i = 1'b1;
        dm_req_addr_i  = 32'h0000_0018;
        for (int c = 0; c < 3; c++) begin
            mid();
            check("t4_stall_dm_ready", dm_req_ready_o, 0);
            check("t4_stall_ram_ena", ram_ena_o, 0);
            check("t4_stall_if_rsp_valid", if_rsp_valid_o, 1);
            check("t4_stall_if_rsp_rdata", if_rsp_rdata_o, 32'hA500_0003);
            tick();
        end
        if_rsp_ready_i = 1'b1;
        mid();
        check("t4_release_dm_ready", dm_req_ready_o, 1);
        check("t4_release_ram_ena", ram_ena_o, 1);
        check("t4_release_ram_addr", ram_addr_o, 6);
        check("t4_release_if_rdata", if_rsp_rdata_o, 32'hA500_0003);
        tick();
        dm_req_valid_i = 1'b0;
        mid();
        check("t4_dm_rsp_valid", dm_rsp_valid_o, 1);
        check("t4_dm_rsp_rdata", dm_rsp_rdata_o, 32'hA500_0006);
        check("t4_if_rsp_valid", if_rsp_valid_o, 0);

        // Test 5: top word address, upper bits and byte offset ignored
        tick();
        if_req_valid_i = 1'b1;
        if_req_addr_i  = 32'hFFFF_1FFC;
        mid();
        check("t5_if_addr", ram_addr_o, 10'h3FF);
        tick();
        if_req_valid_i = 1'b0;
        dm_req_valid_i = 1'b1;
        dm_req_addr_i  = 32'hFFFF_1FFE;
        mid();
        check("t5_if_rdata", if_rsp_rdata_o, 32'hA500_03FF);
        check("t5_dm_addr", ram_addr_o, 10'h3FF);
        check("t5_dm_ready", dm_req_ready_o, 1);
        tick();
        dm_req_valid_i = 1'b0;
        mid();
        check("t5_dm_rdata", dm_rsp_rdata_o, 32'hA500_03FF);

        // Test 6: reset asserted mid-stall
        tick();
        if_req_valid_i = 1'b1;
        if_req_addr_i  = 32'h0000_001C;
        if_rsp_ready_i = 1'b0;
        mid();
        check("t6_if_ready", if_req_ready_o, 1);
        tick();
        dm_req_valid_i = 1'b1;
        dm_req_addr_i  = 32'h0000_0020;
        mid();
        check("t6_stall_valid", if_rsp_valid_o, 1);
        check("t6_stall_ram_ena", ram_ena_o, 0);
        rst_i = 1'b1;
        #1;
        check("t6_rst_if_rsp_valid", if_rsp_valid_o, 0);
        check("t6_rst_if_rsp_rdata", if_rsp_rdata_o, 0);
        check("t6_rst_ram_ena", ram_ena_o, 0);
        check("t6_rst_if_ready", if_req_ready_o, 0);
        check("t6_rst_dm_ready", dm_req_ready_o, 0);
        tick();
        rst_i = 1'b0;
        if_rsp_ready_i = 1'b1;
        mid();
        check("t6_tie_if_ready", if_req_ready_o, 1);
        check("t6_tie_dm_ready", dm_req_ready_o, 0);
        check("t6_tie_addr", ram_addr_o, 7);
        tick();
        if_req_valid_i = 1'b0;
        dm_req_valid_i = 1'b0;
        mid();
        check("t6_after_rdata", if_rsp_rdata_o, 32'hA500_0007);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
